// File: rtl/hex_line_parser.sv
// hex_line_parser: streaming ASCII hex-line parser. Takes one char per cycle and emits one DATA_W-bit word per line.
// Optional '#' comment support is compiled in when HEX_PARSER_COMMENT_EN is defined.
module hex_line_parser #(
    parameter int DATA_W = 128
) (
    input  logic              Clk_CI,
    input  logic              Reset_RBI,
    input  logic [7:0]        CharIn_DI,
    input  logic              CharValid_SI,
    output logic              CharReady_SO,
    output logic [DATA_W-1:0] Word_DO,
    output logic              WordValid_SO,
    input  logic              WordReady_SI,
    output logic              Error_SO
);
    localparam int NIBBLES = DATA_W / 4;
    localparam int CNT_W   = $clog2(NIBBLES + 1);

    typedef enum logic [2:0] {LEAD, DIGITS, TRAIL, OUT, ERR, CMNT} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] sreg_reg;
    logic [DATA_W-1:0] word_reg;
    logic              char_ready_reg;
    logic              word_valid_reg;
    logic              error_reg;

    logic       is_sp;
    logic       is_lf;
    logic       is_digit;
    logic       is_lower;
    logic       is_upper;
    logic       is_hex;
    logic       is_hash;
    logic       cnt_full;
    logic       char_fire;
    logic [3:0] nib;

    assign is_sp    = (CharIn_DI == 8'h20) || (CharIn_DI == 8'h0D);
    assign is_lf    = (CharIn_DI == 8'h0A);
    assign is_digit = (CharIn_DI >= 8'h30) && (CharIn_DI <= 8'h39);
    assign is_lower = (CharIn_DI >= 8'h61) && (CharIn_DI <= 8'h66);
    assign is_upper = (CharIn_DI >= 8'h41) && (CharIn_DI <= 8'h46);
    assign is_hex   = is_digit || is_lower || is_upper;
    // ASCII letters a-f / A-F have low nibble 1..6, so adding 9 yields 10..15.
    assign nib      = CharIn_DI[3:0] + ((is_lower || is_upper) ? 4'd9 : 4'd0);

`ifdef HEX_PARSER_COMMENT_EN
    assign is_hash = (CharIn_DI == 8'h23);
`else
    assign is_hash = 1'b0;
`endif

    assign cnt_full  = (cnt_reg == CNT_W'(NIBBLES));
    assign char_fire = CharValid_SI && char_ready_reg;

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_reg      <= LEAD;
            cnt_reg        <= '0;
            sreg_reg       <= '0;
            word_reg       <= '0;
            char_ready_reg <= 1'b0;
            word_valid_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            error_reg <= 1'b0;
            if (state_reg == OUT) begin
                if (WordReady_SI) begin
                    state_reg      <= LEAD;
                    cnt_reg        <= '0;
                    word_valid_reg <= 1'b0;
                    char_ready_reg <= 1'b1;
                end
            end else begin
                char_ready_reg <= 1'b1;
                if (char_fire) begin
                    case (state_reg)
                        LEAD: begin
                            if (is_sp || is_lf) begin
                                cnt_reg <= '0;
                            end else if (is_hex) begin
                                sreg_reg  <= {{(DATA_W-4){1'b0}}, nib};
                                cnt_reg   <= CNT_W'(1);
                                state_reg <= DIGITS;
                            end else if (is_hash) begin
                                state_reg <= CMNT;
                            end else begin
                                state_reg <= ERR;
                                error_reg <= 1'b1;
                            end
                        end
                        DIGITS: begin
                            if (is_hex && !cnt_full) begin
                                sreg_reg <= {sreg_reg[DATA_W-5:0], nib};
                                cnt_reg  <= cnt_reg + CNT_W'(1);
                            end else if (is_sp && cnt_full) begin
                                state_reg <= TRAIL;
                            end else if (is_hash && cnt_full) begin
                                state_reg <= CMNT;
                            end else if (is_lf && cnt_full) begin
                                state_reg      <= OUT;
                                word_reg       <= sreg_reg;
                                word_valid_reg <= 1'b1;
                                char_ready_reg <= 1'b0;
                            end else if (is_lf) begin
                                // Too-short line ended by LF: nothing left to discard.
                                state_reg <= LEAD;
                                cnt_reg   <= '0;
                                error_reg <= 1'b1;
                            end else begin
                                state_reg <= ERR;
                                error_reg <= 1'b1;
                            end
                        end
                        TRAIL: begin
                            if (is_sp) begin
                                state_reg <= TRAIL;
                            end else if (is_lf) begin
                                state_reg      <= OUT;
                                word_reg       <= sreg_reg;
                                word_valid_reg <= 1'b1;
                                char_ready_reg <= 1'b0;
                            end else if (is_hash) begin
                                state_reg <= CMNT;
                            end else begin
                                state_reg <= ERR;
                                error_reg <= 1'b1;
                            end
                        end
                        ERR: begin
                            if (is_lf) begin
                                state_reg <= LEAD;
                                cnt_reg   <= '0;
                            end
                        end
                        CMNT: begin
                            // A full digit count means the comment trails a complete word.
                            if (is_lf && cnt_full) begin
                                state_reg      <= OUT;
                                word_reg       <= sreg_reg;
                                word_valid_reg <= 1'b1;
                                char_ready_reg <= 1'b0;
                            end else if (is_lf) begin
                                state_reg <= LEAD;
                                cnt_reg   <= '0;
                            end
                        end
                        default: begin
                            state_reg <= LEAD;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign CharReady_SO = char_ready_reg;
    assign Word_DO      = word_reg;
    assign WordValid_SO = word_valid_reg;
    assign Error_SO     = error_reg;

endmodule

// File: tb/tb_hex_line_parser.sv
// Testbench for hex_line_parser: directed and random lines checked against a string-level line model.
`timescale 1ns/1ps
module tb_hex_line_parser;
    localparam int DATA_W = 128;
    localparam int NIB    = DATA_W / 4;
`ifdef HEX_PARSER_COMMENT_EN
    localparam bit CMT = 1'b1;
`else
    localparam bit CMT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        char_in = 8'h00;
    logic              char_valid = 1'b0;
    logic              char_ready;
    logic [DATA_W-1:0] word;
    logic              word_valid;
    logic              word_ready = 1'b1;
    logic              error;

    always #5 clk = ~clk;

    hex_line_parser #(.DATA_W(DATA_W)) dut (
        .Clk_CI       (clk),
        .Reset_RBI    (rst_n),
        .CharIn_DI    (char_in),
        .CharValid_SI (char_valid),
        .CharReady_SO (char_ready),
        .Word_DO      (word),
        .WordValid_SO (word_valid),
        .WordReady_SI (word_ready),
        .Error_SO     (error)
    );

    int tests  = 0;
    int failed = 0;

    logic [DATA_W-1:0] got_q[$];
    int err_cnt      = 0;
    int valid_cycles = 0;

    always @(negedge clk) begin
        if (word_valid && word_ready) got_q.push_back(word);
        if (word_valid) valid_cycles++;
        if (error) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit c_is_sp(input byte unsigned c);
        return (c == 8'h20) || (c == 8'h0D);
    endfunction

    function automatic bit c_is_hex(input byte unsigned c);
        return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
    endfunction

    function automatic logic [3:0] c_val(input byte unsigned c);
        if (c >= "0" && c <= "9") return 4'(c - 8'h30);
        if (c >= "a" && c <= "f") return 4'(c - 8'h61 + 10);
        return 4'(c - 8'h41 + 10);
    endfunction

    function automatic string app(input string s, input byte unsigned c);
        string t;
        t = " ";
        t.putc(0, c);
        return {s, t};
    endfunction

    // Line-level reference: trim spaces, require exactly NIB hex digits, allow trailing comment if enabled.
    function automatic void model_line(input string s, output bit has_word, output bit err,
                                       output logic [DATA_W-1:0] w);
        int i = 0;
        int n = 0;
        int len = s.len();
        has_word = 1'b0;
        err      = 1'b0;
        w        = '0;
        while (i < len && c_is_sp(s[i])) i++;
        if (i == len) return;
        if (CMT && s[i] == 8'h23) return;
        while (i < len && c_is_hex(s[i])) begin
            if (n < NIB) w = (w << 4) | DATA_W'(c_val(s[i]));
            n++;
            i++;
        end
        if (n != NIB) begin
            err = 1'b1;
            return;
        end
        while (i < len && c_is_sp(s[i])) i++;
        if (i == len || (CMT && s[i] == 8'h23)) has_word = 1'b1;
        else err = 1'b1;
    endfunction

    function automatic string rand_digits(input int n);
        string s = "";
        for (int k = 0; k < n; k++) begin
            int v = $urandom_range(0, 15);
            if (v < 10) s = app(s, 8'(8'h30 + v));
            else if ($urandom_range(0, 1) == 1) s = app(s, 8'(8'h61 + v - 10));
            else s = app(s, 8'(8'h41 + v - 10));
        end
        return s;
    endfunction

    function automatic string rand_spaces(input int maxn);
        string s = "";
        int n = $urandom_range(0, maxn);
        for (int k = 0; k < n; k++) s = app(s, ($urandom_range(0, 3) == 0) ? 8'h0D : 8'h20);
        return s;
    endfunction

    task automatic send_char(input byte unsigned c);
        bit done = 1'b0;
        char_in    = c;
        char_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (char_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL char_accept: char 0x%02h not accepted, ready=%0b required=1", c, char_ready);
        end
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        send_char(8'h0A);
    endtask

    task automatic settle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (char_ready && !word_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL %s_settle: ready=%0b valid=%0b required ready=1 valid=0", name, char_ready, word_valid);
        end
    endtask

    task automatic run_line(input string name, input string s);
        bit exp_word, exp_err;
        logic [DATA_W-1:0] exp_w;
        int q0, e0, nwords, nerrs;
        model_line(s, exp_word, exp_err, exp_w);
        q0 = got_q.size();
        e0 = err_cnt;
        send_line(s);
        tests++;
        if (word_valid !== exp_word) begin
            failed++;
            $display("FAIL %s_latency: WordValid=%0b required %0b one cycle after LF", name, word_valid, exp_word);
        end
        settle(name);
        nwords = got_q.size() - q0;
        nerrs  = err_cnt - e0;
        tests++;
        if (nwords !== int'(exp_word)) begin
            failed++;
            $display("FAIL %s_words: got %0d words required %0d", name, nwords, int'(exp_word));
        end
        if (exp_word && nwords > 0) begin
            tests++;
            if (got_q[got_q.size()-1] !== exp_w) begin
                failed++;
                $display("FAIL %s_value: got %h required %h", name, got_q[got_q.size()-1], exp_w);
            end
        end
        tests++;
        if (nerrs !== int'(exp_err)) begin
            failed++;
            $display("FAIL %s_error: got %0d pulses required %0d", name, nerrs, int'(exp_err));
        end
        $display("[TB] line %s len=%0d word=%0b err=%0b", name, s.len(), exp_word, exp_err);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (char_ready !== 1'b0 || word_valid !== 1'b0 || error !== 1'b0 || word !== '0) begin
            failed++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b err=%0b word=%h required all 0",
                     char_ready, word_valid, error, word);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (char_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_ready: CharReady=%0b required 1 after release", char_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int v0 = valid_cycles;
        run_line("basic", "  000102030405060708090a0b0c0d0e0f  ");
        tests++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            failed++;
            $display("FAIL basic_const: word missing or wrong, required 000102030405060708090a0b0c0d0e0f");
        end
        tests++;
        if (valid_cycles - v0 !== 1) begin
            failed++;
            $display("FAIL basic_valid_cycles: got %0d required 1", valid_cycles - v0);
        end
    endtask

    task automatic test_empty_lines();
        run_line("empty", "");
        run_line("cr_only", app("", 8'h0D));
        run_line("spaces", "   ");
        run_line("aes_key", "2B7E151628AED2A6ABF7158809CF4F3C");
        tests++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            failed++;
            $display("FAIL aes_key_const: word missing or wrong, required 2b7e151628aed2a6abf7158809cf4f3c");
        end
    endtask

    task automatic test_malformed();
        string s;
        run_line("short31", rand_digits(31));
        run_line("after_short", rand_digits(32));
        run_line("long33", rand_digits(33));
        s = {"00", rand_digits(10), "g", rand_digits(19)};
        run_line("bad_char", s);
        run_line("hash_line", {rand_digits(32), " # x"});
        run_line("after_bad", {" ", rand_digits(32), " "});
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            string s;
            string d;
            int kind = $urandom_range(0, 6);
            s = rand_spaces(3);
            case (kind)
                0: s = {s, rand_digits(32)};
                1: s = {s, rand_digits($urandom_range(1, 31))};
                2: s = {s, rand_digits($urandom_range(33, 36))};
                3: begin
                    d = rand_digits(32);
                    case ($urandom_range(0, 3))
                        0: d.putc($urandom_range(0, 31), "g");
                        1: d.putc($urandom_range(0, 31), "z");
                        2: d.putc($urandom_range(0, 31), "#");
                        default: d.putc($urandom_range(0, 31), "!");
                    endcase
                    s = {s, d};
                end
                4: s = s;
                5: s = {s, rand_digits(32), rand_spaces(2), "# c"};
                default: s = {s, rand_digits(32), " x"};
            endcase
            s = {s, rand_spaces(3)};
            run_line($sformatf("rand%0d_k%0d", t, kind), s);
        end
    endtask

    task automatic test_backpressure();
        string s;
        bit hw, er;
        logic [DATA_W-1:0] exp_w;
        int q0;
        s = rand_digits(32);
        model_line(s, hw, er, exp_w);
        q0 = got_q.size();
        word_ready = 1'b0;
        send_line(s);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests++;
            if (word_valid !== 1'b1 || word !== exp_w || char_ready !== 1'b0) begin
                failed++;
                $display("FAIL bp_hold: valid=%0b ready=%0b word=%h required valid=1 ready=0 word=%h",
                         word_valid, char_ready, word, exp_w);
            end
        end
        @(posedge clk);
        #1;
        word_ready = 1'b1;
        settle("bp");
        tests++;
        if (got_q.size() - q0 !== 1 || got_q[got_q.size()-1] !== exp_w) begin
            failed++;
            $display("FAIL bp_accept: got %0d words last=%h required 1 word %h",
                     got_q.size() - q0, (got_q.size() > 0) ? got_q[got_q.size()-1] : '0, exp_w);
        end
        run_line("bp_after", rand_digits(32));
    endtask

    task automatic test_mid_reset();
        string d;
        int e0 = err_cnt;
        d = rand_digits(16);
        for (int i = 0; i < 16; i++) send_char(d[i]);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (char_ready !== 1'b0 || word_valid !== 1'b0 || error !== 1'b0 || word !== '0) begin
            failed++;
            $display("FAIL midreset_outputs: ready=%0b valid=%0b err=%0b word=%h required all 0",
                     char_ready, word_valid, error, word);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (err_cnt !== e0) begin
            failed++;
            $display("FAIL midreset_error: got %0d pulses required 0", err_cnt - e0);
        end
        run_line("post_reset", rand_digits(32));
        run_line("comment", {rand_digits(32), " # key"});
        run_line("comment_lead", " # only a comment");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_lines();
        test_malformed();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
